// File: rtl/mcp23s17_sequencer.sv
// mcp23s17_sequencer: configures an MCP23S17 expander over an SPI master and
// periodically reads both joystick button groups into JOY_P0/JOY_P1.
// Optional macro MCP_INTA_EN: enables INTA pins and INTA-triggered polling.
module mcp23s17_sequencer #(
    parameter int unsigned POLL_DIV    = 200000,
    parameter int unsigned SEL_SETTLE  = 64,
    parameter int unsigned SPI_TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        LOCKED,
    input  logic        JS_INTA,
    output logic        SPI_START,
    output logic [23:0] SPI_TX,
    input  logic        SPI_BUSY,
    input  logic        SPI_DONE,
    input  logic [7:0]  SPI_RX,
    output logic        JOY_SEL,
    output logic [15:0] JOY_P0,
    output logic [15:0] JOY_P1,
    output logic        JOY_VALID,
    output logic        CFG_DONE
);
    localparam int unsigned PW = $clog2(POLL_DIV + 1);
    localparam int unsigned SW = $clog2(SEL_SETTLE + 1);
    localparam int unsigned TW = $clog2(SPI_TIMEOUT + 1);
`ifdef MCP_INTA_EN
    localparam int unsigned CFG_N = 7;
`else
    localparam int unsigned CFG_N = 5;
`endif

    typedef enum logic [2:0] {
        WAIT_LOCK, CFG, IDLE, SEL, READ_A, READ_B, PUBLISH
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cfg_idx_q, cfg_idx_d;
    logic          out_q, out_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          start_q, start_d;
    logic [23:0]   tx_q, tx_d;
    logic          sel_q, sel_d;
    logic [15:0]   p0_q, p0_d, p1_q, p1_d;
    logic          valid_q, valid_d;
    logic          cfg_done_q, cfg_done_d;
    logic [7:0]    a0_q, a0_d, b0_q, b0_d, a1_q, a1_d;

    logic          poll_wrap, done_ok, tmo_hit, can_start, poll_req;
    logic          issue;
    logic [23:0]   frame;

    // Configuration write table, in issue order
    function automatic logic [23:0] cfg_frame(input logic [2:0] idx);
        case (idx)
            3'd0:    cfg_frame = 24'h400A40;
            3'd1:    cfg_frame = 24'h4000FF;
            3'd2:    cfg_frame = 24'h4001FF;
            3'd3:    cfg_frame = 24'h400CFF;
            3'd4:    cfg_frame = 24'h400DFF;
            3'd5:    cfg_frame = 24'h4004FF;
            3'd6:    cfg_frame = 24'h4005FF;
            default: cfg_frame = 24'h400A40;
        endcase
    endfunction

`ifdef MCP_INTA_EN
    logic inta_s1_q, inta_s2_q;
    logic pend_q, pend_d;

    // Two-flop synchronizer for the asynchronous INTA pin
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            inta_s1_q <= 1'b1;
            inta_s2_q <= 1'b1;
        end else begin
            inta_s1_q <= JS_INTA;
            inta_s2_q <= inta_s1_q;
        end
    end

    assign poll_req = poll_wrap | ~inta_s2_q | pend_q;
`else
    logic unused_inta;
    assign unused_inta = JS_INTA;
    assign poll_req    = poll_wrap;
`endif

    assign poll_wrap = (poll_q == PW'(POLL_DIV - 1));
    assign done_ok   = out_q & SPI_DONE;
    assign tmo_hit   = out_q & ~SPI_DONE & (tmo_q == TW'(SPI_TIMEOUT - 1));
    assign can_start = ~out_q & ~SPI_BUSY;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= WAIT_LOCK;
            cfg_idx_q  <= '0;
            out_q      <= 1'b0;
            tmo_q      <= '0;
            settle_q   <= '0;
            poll_q     <= '0;
            start_q    <= 1'b0;
            tx_q       <= '0;
            sel_q      <= 1'b0;
            p0_q       <= 16'hFFFF;
            p1_q       <= 16'hFFFF;
            valid_q    <= 1'b0;
            cfg_done_q <= 1'b0;
            a0_q       <= 8'hFF;
            b0_q       <= 8'hFF;
            a1_q       <= 8'hFF;
`ifdef MCP_INTA_EN
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cfg_idx_q  <= cfg_idx_d;
            out_q      <= out_d;
            tmo_q      <= tmo_d;
            settle_q   <= settle_d;
            poll_q     <= poll_d;
            start_q    <= start_d;
            tx_q       <= tx_d;
            sel_q      <= sel_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            valid_q    <= valid_d;
            cfg_done_q <= cfg_done_d;
            a0_q       <= a0_d;
            b0_q       <= b0_d;
            a1_q       <= a1_d;
`ifdef MCP_INTA_EN
            pend_q     <= pend_d;
`endif
        end
    end

    // Next-state, frame issue, capture and publish logic
    always_comb begin
        state_d    = state_q;
        cfg_idx_d  = cfg_idx_q;
        out_d      = out_q;
        tmo_d      = tmo_q;
        settle_d   = settle_q;
        poll_d     = poll_q;
        start_d    = 1'b0;
        tx_d       = tx_q;
        sel_d      = sel_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        valid_d    = 1'b0;
        cfg_done_d = cfg_done_q;
        a0_d       = a0_q;
        b0_d       = b0_q;
        a1_d       = a1_q;
        issue      = 1'b0;
        frame      = 24'h000000;
`ifdef MCP_INTA_EN
        pend_d     = pend_q;
        if (!inta_s2_q && (state_q == SEL || state_q == READ_A ||
                           state_q == READ_B || state_q == PUBLISH))
            pend_d = 1'b1;
`endif

        if (state_q != WAIT_LOCK)
            poll_d = poll_wrap ? '0 : poll_q + PW'(1);
        if (out_q)
            tmo_d = tmo_q + TW'(1);

        case (state_q)
            WAIT_LOCK: begin
                poll_d = '0;
                out_d  = 1'b0;
`ifdef MCP_INTA_EN
                pend_d = 1'b0;
`endif
                if (LOCKED && !SPI_BUSY) begin
                    state_d   = CFG;
                    cfg_idx_d = '0;
                end
            end
            CFG: begin
                if (done_ok) begin
                    out_d = 1'b0;
                    if (cfg_idx_q == 3'(CFG_N - 1)) begin
                        cfg_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cfg_idx_d = cfg_idx_q + 3'd1;
                    end
                end else begin
                    issue = 1'b1;
                    frame = cfg_frame(cfg_idx_q);
                end
            end
            IDLE: begin
                if (poll_req) begin
                    state_d  = SEL;
                    sel_d    = 1'b0;
                    settle_d = '0;
`ifdef MCP_INTA_EN
                    pend_d   = 1'b0;
`endif
                end
            end
            SEL: begin
                if (settle_q == SW'(SEL_SETTLE - 1))
                    state_d = READ_A;
                else
                    settle_d = settle_q + SW'(1);
            end
            READ_A: begin
                if (done_ok) begin
                    out_d = 1'b0;
                    if (sel_q) a1_d = SPI_RX;
                    else       a0_d = SPI_RX;
                    state_d = READ_B;
                end else begin
                    issue = 1'b1;
                    frame = 24'h411200;
                end
            end
            READ_B: begin
                if (done_ok) begin
                    out_d = 1'b0;
                    if (!sel_q) begin
                        b0_d     = SPI_RX;
                        sel_d    = 1'b1;
                        settle_d = '0;
                        state_d  = SEL;
                    end else begin
                        // Both groups published together; the PUBLISH cycle shows them
                        p0_d    = {b0_q, a0_q};
                        p1_d    = {SPI_RX, a1_q};
                        valid_d = 1'b1;
                        sel_d   = 1'b0;
                        state_d = PUBLISH;
                    end
                end else begin
                    issue = 1'b1;
                    frame = 24'h411300;
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = WAIT_LOCK;
        endcase

        if (issue && can_start) begin
            start_d = 1'b1;
            tx_d    = frame;
            out_d   = 1'b1;
            tmo_d   = '0;
        end

        // Lost frame or lost lock abandons everything except published data
        if (tmo_hit || !LOCKED) begin
            state_d    = WAIT_LOCK;
            cfg_done_d = 1'b0;
            out_d      = 1'b0;
            start_d    = 1'b0;
            valid_d    = 1'b0;
            p0_d       = p0_q;
            p1_d       = p1_q;
        end
    end

    assign SPI_START = start_q;
    assign SPI_TX    = tx_q;
    assign JOY_SEL   = sel_q;
    assign JOY_P0    = p0_q;
    assign JOY_P1    = p1_q;
    assign JOY_VALID = valid_q;
    assign CFG_DONE  = cfg_done_q;

endmodule

// File: tb/tb_mcp23s17_sequencer.sv
// Testbench for mcp23s17_sequencer: SPI slave model with expander register
// replies, randomized GPIO values and per-scenario checks.
module tb_mcp23s17_sequencer;
    localparam int unsigned POLL_DIV    = 1000;
    localparam int unsigned SEL_SETTLE  = 16;
    localparam int unsigned SPI_TIMEOUT = 1024;
    localparam int          SPI_LAT     = 10;
`ifdef MCP_INTA_EN
    localparam int          N_CFG       = 7;
`else
    localparam int          N_CFG       = 5;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        LOCKED = 1'b0;
    logic        JS_INTA = 1'b1;
    logic        SPI_START;
    logic [23:0] SPI_TX;
    logic        SPI_BUSY;
    logic        SPI_DONE;
    logic [7:0]  SPI_RX;
    logic        JOY_SEL;
    logic [15:0] JOY_P0, JOY_P1;
    logic        JOY_VALID;
    logic        CFG_DONE;

    int checks = 0;
    int failures = 0;

    // SPI slave model state
    logic        mute = 1'b0;
    logic        force_busy = 1'b0;
    logic        spur_done = 1'b0;
    logic        busy_m = 1'b0;
    logic        done_m = 1'b0;
    logic [7:0]  rx_m = 8'h00;
    logic [7:0]  reply_q = 8'h00;
    int          spi_cnt = 0;
    int          start_cnt = 0;
    int          viol = 0;
    int          valid_cnt = 0;
    logic [23:0] frames[$];
    logic        fsel[$];
    logic [7:0]  ga[2];
    logic [7:0]  gb[2];
    logic [15:0] exp_p0 = 16'hFFFF;
    logic [15:0] exp_p1 = 16'hFFFF;
    logic [23:0] cfg_list[7] = '{24'h400A40, 24'h4000FF, 24'h4001FF, 24'h400CFF,
                                 24'h400DFF, 24'h4004FF, 24'h4005FF};

    assign SPI_BUSY = busy_m | force_busy;
    assign SPI_DONE = done_m | spur_done;
    assign SPI_RX   = rx_m;

    mcp23s17_sequencer #(
        .POLL_DIV   (POLL_DIV),
        .SEL_SETTLE (SEL_SETTLE),
        .SPI_TIMEOUT(SPI_TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .LOCKED   (LOCKED),
        .JS_INTA  (JS_INTA),
        .SPI_START(SPI_START),
        .SPI_TX   (SPI_TX),
        .SPI_BUSY (SPI_BUSY),
        .SPI_DONE (SPI_DONE),
        .SPI_RX   (SPI_RX),
        .JOY_SEL  (JOY_SEL),
        .JOY_P0   (JOY_P0),
        .JOY_P1   (JOY_P1),
        .JOY_VALID(JOY_VALID),
        .CFG_DONE (CFG_DONE)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expander register file as seen over SPI
    function automatic logic [7:0] reply(input logic [23:0] f, input logic s);
        if (f[23:16] == 8'h41 && f[15:8] == 8'h12) return ga[s];
        if (f[23:16] == 8'h41 && f[15:8] == 8'h13) return gb[s];
        return 8'h00;
    endfunction

    // SPI slave: DONE SPI_LAT cycles after START, records every frame
    always @(negedge CLK) begin
        done_m = 1'b0;
        if (spi_cnt > 0) begin
            spi_cnt = spi_cnt - 1;
            if (spi_cnt == 0) begin
                busy_m = 1'b0;
                done_m = 1'b1;
                rx_m   = reply_q;
            end
        end
        if (SPI_START) begin
            if (spi_cnt != 0 || force_busy) viol = viol + 1;
            start_cnt = start_cnt + 1;
            frames.push_back(SPI_TX);
            fsel.push_back(JOY_SEL);
            reply_q = reply(SPI_TX, JOY_SEL);
            if (!mute) begin
                busy_m  = 1'b1;
                spi_cnt = SPI_LAT;
            end
        end
        if (JOY_VALID) valid_cnt = valid_cnt + 1;
    end

    task automatic wait_cfg_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (CFG_DONE) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (JOY_VALID) begin ok = 1'b1; break; end
        end
    endtask

    task automatic check_cfg_frames(input string tag);
        checks++;
        if (frames.size() != N_CFG) begin
            failures++;
            $display("FAIL %s_count: got %0d frames, expected %0d", tag, frames.size(), N_CFG);
        end
        for (int i = 0; i < N_CFG && i < frames.size(); i++) begin
            checks++;
            if (frames[i] !== cfg_list[i]) begin
                failures++;
                $display("FAIL %s_frame%0d: got %h expected %h", tag, i, frames[i], cfg_list[i]);
            end
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; LOCKED = 1'b1; JS_INTA = 1'b1;
        repeat (4) @(negedge CLK);
        checks++; if (SPI_START !== 1'b0) begin failures++; $display("FAIL rst_start: got %b expected 0", SPI_START); end
        checks++; if (SPI_TX !== 24'h0) begin failures++; $display("FAIL rst_tx: got %h expected 000000", SPI_TX); end
        checks++; if (JOY_SEL !== 1'b0) begin failures++; $display("FAIL rst_sel: got %b expected 0", JOY_SEL); end
        checks++; if (JOY_P0 !== 16'hFFFF) begin failures++; $display("FAIL rst_p0: got %h expected ffff", JOY_P0); end
        checks++; if (JOY_P1 !== 16'hFFFF) begin failures++; $display("FAIL rst_p1: got %h expected ffff", JOY_P1); end
        checks++; if (JOY_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", JOY_VALID); end
        checks++; if (CFG_DONE !== 1'b0) begin failures++; $display("FAIL rst_cfg_done: got %b expected 0", CFG_DONE); end
    endtask

    task automatic test_config;
        bit ok;
        frames.delete(); fsel.delete();
        RESET_N = 1'b1;
        wait_cfg_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL cfg_done_timeout: CFG_DONE=%b expected 1", CFG_DONE); end
        check_cfg_frames("cfg");
        checks++; if (viol !== 0) begin failures++; $display("FAIL cfg_protocol: got %0d overlapping starts expected 0", viol); end
    endtask

    task automatic test_poll(input logic [7:0] a0, input logic [7:0] b0,
                             input logic [7:0] a1, input logic [7:0] b1);
        bit ok;
        logic [23:0] exp_f[4];
        exp_f[0] = 24'h411200; exp_f[1] = 24'h411300; exp_f[2] = 24'h411200; exp_f[3] = 24'h411300;
        ga[0] = a0; gb[0] = b0; ga[1] = a1; gb[1] = b1;
        exp_p0 = {b0, a0}; exp_p1 = {b1, a1};
        frames.delete(); fsel.delete(); valid_cnt = 0;
        wait_valid(POLL_DIV + 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL poll_timeout: no JOY_VALID within bound"); end
        checks++; if (JOY_P0 !== exp_p0) begin failures++; $display("FAIL poll_p0: got %h expected %h", JOY_P0, exp_p0); end
        checks++; if (JOY_P1 !== exp_p1) begin failures++; $display("FAIL poll_p1: got %h expected %h", JOY_P1, exp_p1); end
        checks++; if (JOY_SEL !== 1'b0) begin failures++; $display("FAIL poll_sel_publish: got %b expected 0", JOY_SEL); end
        repeat (20) @(negedge CLK);
        checks++; if (valid_cnt !== 1) begin failures++; $display("FAIL poll_valid_count: got %0d expected 1", valid_cnt); end
        checks++; if (frames.size() != 4) begin failures++; $display("FAIL poll_frame_count: got %0d expected 4", frames.size()); end
        for (int i = 0; i < 4 && i < frames.size(); i++) begin
            checks++;
            if (frames[i] !== exp_f[i] || fsel[i] !== logic'(i / 2)) begin
                failures++;
                $display("FAIL poll_frame%0d: got %h sel %b expected %h sel %0d", i, frames[i], fsel[i], exp_f[i], i / 2);
            end
        end
    endtask

    task automatic test_busy_spurious;
        bit ok;
        int s0;
        repeat (3) @(negedge CLK);
        s0 = start_cnt;
        spur_done = 1'b1;
        @(negedge CLK);
        spur_done = 1'b0;
        repeat (5) @(negedge CLK);
        checks++; if (start_cnt !== s0) begin failures++; $display("FAIL spur_start: got %0d starts expected %0d", start_cnt, s0); end
        checks++; if (CFG_DONE !== 1'b1) begin failures++; $display("FAIL spur_cfg_done: got %b expected 1", CFG_DONE); end
        checks++; if (JOY_SEL !== 1'b0) begin failures++; $display("FAIL spur_sel: got %b expected 0", JOY_SEL); end
        // Hold BUSY across at least one poll counter wrap
        force_busy = 1'b1;
        s0 = start_cnt; valid_cnt = 0;
        repeat (POLL_DIV + 100) @(negedge CLK);
        checks++; if (start_cnt !== s0) begin failures++; $display("FAIL busy_start: got %0d starts expected %0d", start_cnt, s0); end
        ga[0] = 8'($urandom); gb[0] = 8'($urandom); ga[1] = 8'($urandom); gb[1] = 8'($urandom);
        exp_p0 = {gb[0], ga[0]}; exp_p1 = {gb[1], ga[1]};
        force_busy = 1'b0;
        wait_valid(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL busy_release_timeout: no JOY_VALID after BUSY release"); end
        checks++; if (JOY_P0 !== exp_p0 || JOY_P1 !== exp_p1) begin
            failures++; $display("FAIL busy_data: got %h/%h expected %h/%h", JOY_P0, JOY_P1, exp_p0, exp_p1); end
        repeat (50) @(negedge CLK);
        checks++; if (valid_cnt !== 1) begin failures++; $display("FAIL busy_valid_count: got %0d expected 1", valid_cnt); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL busy_protocol: got %0d violations expected 0", viol); end
    endtask

`ifdef MCP_INTA_EN
    task automatic test_inta;
        bit ok;
        int k;
        ga[0] = 8'($urandom); gb[0] = 8'($urandom); ga[1] = 8'($urandom); gb[1] = 8'($urandom);
        exp_p0 = {gb[0], ga[0]}; exp_p1 = {gb[1], ga[1]};
        valid_cnt = 0;
        @(negedge CLK);
        JS_INTA = 1'b0;
        k = 0;
        while (k < 200) begin
            @(negedge CLK);
            k++;
            if (k == 1) JS_INTA = 1'b1;
            if (SPI_START) break;
        end
        // poll start 3 cycles after the edge, settle, then the first read request
        checks++; if (k < int'(SEL_SETTLE) + 3 || k > int'(SEL_SETTLE) + 5) begin
            failures++; $display("FAIL inta_latency: first START after %0d cycles expected about %0d", k, SEL_SETTLE + 4); end
        repeat (5) @(negedge CLK);
        JS_INTA = 1'b0;
        @(negedge CLK);
        JS_INTA = 1'b1;
        wait_valid(300, ok);
        checks++; if (!ok || JOY_P0 !== exp_p0 || JOY_P1 !== exp_p1) begin
            failures++; $display("FAIL inta_first: ok %b got %h/%h expected %h/%h", ok, JOY_P0, JOY_P1, exp_p0, exp_p1); end
        @(negedge CLK);
        wait_valid(300, ok);
        checks++; if (!ok || JOY_P0 !== exp_p0 || JOY_P1 !== exp_p1) begin
            failures++; $display("FAIL inta_pending: ok %b got %h/%h expected %h/%h", ok, JOY_P0, JOY_P1, exp_p0, exp_p1); end
        repeat (100) @(negedge CLK);
        checks++; if (valid_cnt !== 2) begin failures++; $display("FAIL inta_valid_count: got %0d expected 2", valid_cnt); end
    endtask
`else
    task automatic test_inta;
        int s0;
        valid_cnt = 0;
        s0 = start_cnt;
        @(negedge CLK);
        JS_INTA = 1'b0;
        repeat (5) @(negedge CLK);
        JS_INTA = 1'b1;
        repeat (100) @(negedge CLK);
        checks++; if (start_cnt !== s0) begin failures++; $display("FAIL inta_ignored_start: got %0d starts expected %0d", start_cnt, s0); end
        checks++; if (valid_cnt !== 0) begin failures++; $display("FAIL inta_ignored_valid: got %0d expected 0", valid_cnt); end
    endtask
`endif

    task automatic test_lock_drop;
        bit ok;
        bit hit;
        int s0;
        // New values that would be visible if a publish slipped through
        ga[0] = ~exp_p0[7:0]; gb[0] = ~exp_p0[15:8]; ga[1] = ~exp_p1[7:0]; gb[1] = ~exp_p1[15:8];
        valid_cnt = 0;
        hit = 1'b0;
        for (int i = 0; i < int'(POLL_DIV) + 300; i++) begin
            @(negedge CLK);
            if (SPI_START && SPI_TX == 24'h411300) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin failures++; $display("FAIL lock_find_read_b: no GPIOB read seen"); end
        LOCKED = 1'b0;
        @(negedge CLK);
        checks++; if (CFG_DONE !== 1'b0) begin failures++; $display("FAIL lock_cfg_done: got %b expected 0", CFG_DONE); end
        s0 = start_cnt;
        repeat (30) @(negedge CLK);
        checks++; if (start_cnt !== s0) begin failures++; $display("FAIL lock_start: got %0d starts expected %0d", start_cnt, s0); end
        checks++; if (JOY_P0 !== exp_p0 || JOY_P1 !== exp_p1) begin
            failures++; $display("FAIL lock_hold: got %h/%h expected %h/%h", JOY_P0, JOY_P1, exp_p0, exp_p1); end
        checks++; if (valid_cnt !== 0) begin failures++; $display("FAIL lock_valid: got %0d expected 0", valid_cnt); end
        frames.delete(); fsel.delete();
        LOCKED = 1'b1;
        wait_cfg_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL lock_recfg_timeout: CFG_DONE=%b expected 1", CFG_DONE); end
        check_cfg_frames("lock_recfg");
    endtask

    task automatic test_timeout;
        bit ok;
        bit hit;
        int k;
        mute = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < int'(POLL_DIV) + 300; i++) begin
            @(negedge CLK);
            if (SPI_START) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin failures++; $display("FAIL tmo_no_start: no frame started"); end
        k = 0;
        while (k < 2000) begin
            @(negedge CLK);
            k++;
            if (!CFG_DONE) break;
        end
        checks++; if (k != int'(SPI_TIMEOUT)) begin failures++; $display("FAIL tmo_latency: CFG_DONE fell after %0d cycles expected %0d", k, SPI_TIMEOUT); end
        mute = 1'b0;
        frames.delete(); fsel.delete();
        wait_cfg_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL tmo_recfg_timeout: CFG_DONE=%b expected 1", CFG_DONE); end
        check_cfg_frames("tmo_recfg");
        checks++; if (viol !== 0) begin failures++; $display("FAIL tmo_protocol: got %0d violations expected 0", viol); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_poll(8'hFE, 8'hFF, 8'h7F, 8'hEF);
        for (int i = 0; i < 3; i++)
            test_poll(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        test_busy_spurious();
        test_inta();
        test_lock_drop();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcp23s17_sequencer.md
MCP23S17_SEQUENCER -- requirements
Module: mcp23s17_sequencer

Interface
REQ-001 SHALL have parameter POLL_DIV, default 200000, meaning CLK cycles between periodic poll starts.
REQ-002 SHALL have parameter SEL_SETTLE, default 64, meaning CLK cycles JOY_SEL is held stable before the first read after a change.
REQ-003 SHALL have parameter SPI_TIMEOUT, default 1024, meaning maximum CLK cycles from SPI_START to SPI_DONE.
REQ-004 CLK  in  1  single clock; all logic on its rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous and active-low.
REQ-006 LOCKED  in  1  PLL lock; sequencing only while high.
REQ-007 JS_INTA  in  1  MCP23S17 INTA, active-low, asynchronous.
REQ-008 SPI_START  out  1  one-cycle request pulse to the SPI master.
REQ-009 SPI_TX  out  24  frame {opcode[7:0], reg[7:0], data[7:0]}, stable from SPI_START until SPI_DONE.
REQ-010 SPI_BUSY  in  1  SPI master frame in progress.
REQ-011 SPI_DONE  in  1  one-cycle pulse; frame finished, SPI_RX valid.
REQ-012 SPI_RX  in  8  last byte shifted in.
REQ-013 JOY_SEL  out  1  joystick button-group select.
REQ-014 JOY_P0  out  16  {GPIOB,GPIOA} captured with JOY_SEL=0.
REQ-015 JOY_P1  out  16  {GPIOB,GPIOA} captured with JOY_SEL=1.
REQ-016 JOY_VALID  out  1  one-cycle pulse when JOY_P0/JOY_P1 update.
REQ-017 CFG_DONE  out  1  high once expander configuration is complete.

Function
REQ-018 States SHALL be WAIT_LOCK, CFG, IDLE, SEL, READ_A, READ_B, PUBLISH.
REQ-019 WAIT_LOCK SHALL move to CFG when LOCKED=1 and SPI_BUSY=0.
REQ-020 CFG SHALL issue, in order, writes (opcode 0x40): IOCON 0x0A<=0x40, IODIRA 0x00<=0xFF, IODIRB 0x01<=0xFF, GPPUA 0x0C<=0xFF, GPPUB 0x0D<=0xFF, then set CFG_DONE and enter IDLE.
REQ-021 SPI_START SHALL be issued only when SPI_BUSY=0 and no frame is outstanding; the next frame SHALL NOT start before SPI_DONE of the previous one.
REQ-022 SPI_DONE received with no outstanding frame SHALL be ignored.
REQ-023 No SPI_DONE within SPI_TIMEOUT cycles of SPI_START SHALL clear CFG_DONE and return to WAIT_LOCK.
REQ-024 IDLE SHALL start a poll when the free-running poll counter wraps (POLL_DIV-1 to 0); the counter SHALL run in all states except WAIT_LOCK.
REQ-025 Poll: JOY_SEL<=0, wait SEL_SETTLE, read GPIOA (0x41,0x12,0x00), read GPIOB (0x41,0x13,0x00); JOY_SEL<=1, wait SEL_SETTLE, repeat both reads; then PUBLISH.
REQ-026 Read data SHALL be taken from SPI_RX on the SPI_DONE cycle into shadow registers; JOY_P0/JOY_P1 SHALL change only in PUBLISH, together, with JOY_VALID=1 that cycle.
REQ-027 JOY_SEL SHALL return to 0 in PUBLISH; a poll counter wrap during a poll SHALL NOT start a second overlapping poll (it is dropped).
REQ-028 LOCKED falling in any state SHALL clear CFG_DONE, suppress further SPI_START and enter WAIT_LOCK; JOY_P0/JOY_P1 SHALL hold.

Reset
REQ-029 RESET_N low SHALL asynchronously force WAIT_LOCK, SPI_START=0, SPI_TX=0, JOY_SEL=0, JOY_P0=JOY_P1=16'hFFFF, JOY_VALID=0, CFG_DONE=0, counters=0, pending flag=0.
REQ-030 Reset release SHALL take effect on the first CLK edge with RESET_N high; no output changes before it.

Configuration
REQ-031 With MCP_INTA_EN defined, CFG SHALL append GPINTENA 0x04<=0xFF and GPINTENB 0x05<=0xFF, JS_INTA SHALL pass a 2-flop synchronizer, and a synchronized low in IDLE SHALL start a poll on the next cycle.
REQ-032 With MCP_INTA_EN defined, JS_INTA low during a poll SHALL set a pending flag causing exactly one further poll after PUBLISH.
REQ-033 Without MCP_INTA_EN, JS_INTA SHALL be ignored, CFG SHALL issue exactly five writes and polls SHALL be periodic only.

Verification
REQ-034 Reset, LOCKED=1, SPI model DONE 10 cycles after START -> frames 400A40,4000FF,4001FF,400CFF,400DFF in order, then CFG_DONE=1.
REQ-035 Poll with model returning A=0xFE,B=0xFF at SEL=0 and A=0x7F,B=0xEF at SEL=1 -> one JOY_VALID pulse, JOY_P0=16'hFFFE, JOY_P1=16'hEF7F.
REQ-036 SPI_BUSY held high 50 cycles in IDLE at a counter wrap -> no SPI_START until SPI_BUSY=0; spurious SPI_DONE in IDLE -> no state change.
REQ-037 Model never asserts SPI_DONE -> after 1024 cycles CFG_DONE=0, WAIT_LOCK, reconfiguration restarts.
REQ-038 LOCKED dropped mid-READ_B -> CFG_DONE=0 next cycle, no new SPI_START, JOY_P0/JOY_P1 unchanged; LOCKED=1 again -> full CFG replayed.
REQ-039 MCP_INTA_EN defined, JS_INTA pulsed low in IDLE and again mid-poll -> poll starts 3 cycles after first edge, exactly two JOY_VALID pulses total.
